// File: rtl/alu_serial_ctrl_if.sv
// Command/result bundle for the bit-serial ALU sequencer (ALU_SERIAL_OVF_EN selects overflow/SLT mode in the core).
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready on the command side, out_valid/out_ready on the result side.
`timescale 1ns/1ps
interface alu_serial_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             cout;
    logic             overflow;
    logic             busy;

    // Initiator of commands / consumer of results.
    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, zero, cout, overflow, busy
    );

    // The sequencer itself.
    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, zero, cout, overflow, busy
    );
endinterface

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: one 1-bit slice driven LSB-first; optional macro ALU_SERIAL_OVF_EN enables overflow and signed SLT.
// Latency: WIDTH cycles from command accept to out_valid; next accept one cycle after the result handshake.
// Backpressure: in_ready only in IDLE; result and flags held in DONE until out_ready.
`timescale 1ns/1ps
module alu_serial_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    alu_serial_ctrl_if.slave   bus
);
    localparam int             CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [3:0]         op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cout_q, cout_d;
`ifdef ALU_SERIAL_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    // Slice signals for the bit currently addressed by cnt_q.
    logic               a_bit, mb_bit, sum_bit, slice_cout, res_bit, ovf_bit;
    logic               is_arith, is_slt;

    assign a_bit      = a_q[cnt_q];
    assign mb_bit     = b_q[cnt_q] ^ op_q[3];
    assign sum_bit    = a_bit ^ mb_bit ^ carry_q;
    assign slice_cout = (a_bit & mb_bit) | (a_bit & carry_q) | (mb_bit & carry_q);
    assign is_slt     = (op_q[2:0] == 3'b101);
    assign is_arith   = (op_q[2:0] == 3'b010) || is_slt;
`ifdef ALU_SERIAL_OVF_EN
    // At the MSB, carry_q is the MSB carry-in, so this is the signed overflow.
    assign ovf_bit    = carry_q ^ slice_cout;
`else
    assign ovf_bit    = 1'b0;
`endif

    // Per-bit function select; SLT feeds LESS = 0 here and patches bit 0 at the end.
    always_comb begin
        res_bit = 1'b0;
        case (op_q[2:0])
            3'b000:  res_bit = a_bit & mb_bit;
            3'b001:  res_bit = a_bit | mb_bit;
            3'b010:  res_bit = sum_bit;
            3'b011:  res_bit = a_bit ^ mb_bit;
            default: res_bit = 1'b0;
        endcase
    end

    // Next-state and datapath updates for IDLE/RUN/DONE.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
`ifdef ALU_SERIAL_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d      = bus.a;
                    b_d      = bus.b;
                    op_d     = bus.op;
                    cnt_d    = '0;
                    carry_d  = bus.op[3];
                    result_d = '0;
                    cout_d   = 1'b0;
`ifdef ALU_SERIAL_OVF_EN
                    ovf_d    = 1'b0;
`endif
                    state_d  = RUN;
                end
            end
            RUN: begin
                result_d[cnt_q] = res_bit;
                carry_d         = slice_cout;
                cnt_d           = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    cout_d = is_arith & slice_cout;
`ifdef ALU_SERIAL_OVF_EN
                    ovf_d  = is_arith & ovf_bit;
`endif
                    // SLT set bit: sign of A-B, corrected by overflow when enabled.
                    if (is_slt) begin
                        result_d[0] = sum_bit ^ ovf_bit;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
`ifdef ALU_SERIAL_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
`ifdef ALU_SERIAL_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.result    = result_q;
    assign bus.zero      = ~|result_q;
    assign bus.cout      = cout_q;
`ifdef ALU_SERIAL_OVF_EN
    assign bus.overflow  = ovf_q;
`else
    assign bus.overflow  = 1'b0;
`endif
endmodule
